// File: rtl/tlu_pkg.sv
// Shared definitions for the TLU DUT-side receiver: FSM state encoding,
// field widths and the ID masking helper.
package tlu_pkg;

    localparam int TRIG_ID_W = 31;
    localparam int TIMEOUT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOW,
        CLK_HI,
        CLK_LO,
        DONE,
        HOLD
    } tlu_state_t;

    // Low n bits set; n=0 gives an all-zero mask.
    function automatic logic [TRIG_ID_W-1:0] id_mask(input logic [4:0] n);
        return TRIG_ID_W'((32'd1 << n) - 32'd1);
    endfunction

endpackage

// File: rtl/tlu_in_sync.sv
// Two-flop synchronizer for an asynchronous TLU cable line, with a third
// register that provides a rising-edge indication on the synchronized level.
module tlu_in_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise
);

    logic meta;
    logic level_q;
    logic prev;

    // Synchronizer chain plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta    <= 1'b0;
            level_q <= 1'b0;
            prev    <= 1'b0;
        end else begin
            meta    <= pin;
            level_q <= meta;
            prev    <= level_q;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~prev;

endmodule

// File: rtl/tlu_dut_rx.sv
// DUT-side TLU trigger receiver: answers a trigger with TLU_BUSY, clocks the
// trigger ID out of the master LSB first, checks ID continuity and strobes the
// result. Outputs are registered from the current FSM state, so each lags the
// state by one cycle.
// Optional feature: define TLU_DUT_RX_TIMESTAMP_EN to add a 32-bit free-running
// counter and the TRIG_TIMESTAMP output.
module tlu_dut_rx
    import tlu_pkg::*;
#(
    parameter int CLK_HALF_PERIOD = 4
) (
    input  logic                 SYS_CLK,
    input  logic                 SYS_RST,
    input  logic                 ENABLE,
    input  logic [4:0]           N_BITS_TRIGGER_ID,
    input  logic [TIMEOUT_W-1:0] CONF_TIME_OUT,
    input  logic                 DUT_HOLD,
    input  logic                 TLU_TRIGGER,
    input  logic                 TLU_RESET,
    output logic                 TLU_BUSY,
    output logic                 TLU_CLOCK,
    output logic                 TRIG_VALID,
    output logic [TRIG_ID_W-1:0] TRIG_ID,
    output logic                 ID_ERROR,
    output logic                 TIME_OUT,
    output logic                 TLU_RESET_PULSE,
    output logic [15:0]          TRIG_CNT
`ifdef TLU_DUT_RX_TIMESTAMP_EN
    ,
    output logic [31:0]          TRIG_TIMESTAMP
`endif
);

    tlu_state_t           state;
    tlu_state_t           next_state;
    logic [TIMEOUT_W-1:0] timer;
    logic [4:0]           n_lat;
    logic [4:0]           bit_cnt;
    logic [TRIG_ID_W-1:0] shreg;
    logic [TRIG_ID_W-1:0] rx_id;
    logic [TRIG_ID_W-1:0] expect_id;
    logic                 have_prev;
    logic                 trg_s;
    logic                 trg_rise;
    logic                 rst_rise;
    logic                 rst_level_unused;
    logic                 half_done;
    logic                 tmo_fire;
    logic                 start;
    logic                 sample;

    tlu_in_sync u_trg_sync (
        .clk   (SYS_CLK),
        .rst   (SYS_RST),
        .pin   (TLU_TRIGGER),
        .level (trg_s),
        .rise  (trg_rise)
    );

    tlu_in_sync u_rst_sync (
        .clk   (SYS_CLK),
        .rst   (SYS_RST),
        .pin   (TLU_RESET),
        .level (rst_level_unused),
        .rise  (rst_rise)
    );

    assign half_done = (timer == TIMEOUT_W'(CLK_HALF_PERIOD - 1));
    assign tmo_fire  = (state == WAIT_LOW) && trg_s &&
                       (CONF_TIME_OUT != '0) && (timer == CONF_TIME_OUT - 16'd1);
    assign start     = (state == IDLE) && (next_state == WAIT_LOW);
    assign sample    = (state == CLK_LO) && half_done;
    assign rx_id     = shreg & id_mask(n_lat);

    // State register.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state logic; a released trigger line wins over a coincident timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (trg_rise && ENABLE) next_state = WAIT_LOW;
            WAIT_LOW: begin
                if (!trg_s)        next_state = (n_lat == 5'd0) ? DONE : CLK_HI;
                else if (tmo_fire) next_state = HOLD;
            end
            CLK_HI:   if (half_done) next_state = CLK_LO;
            CLK_LO:   if (half_done)
                          next_state = (bit_cnt == n_lat - 5'd1) ? DONE : CLK_HI;
            DONE:     next_state = HOLD;
            HOLD:     if (!DUT_HOLD && !trg_s) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Shared phase/timeout timer, restarted on every state change.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST || (state != next_state)) timer <= '0;
        else                                  timer <= timer + 16'd1;
    end

    // Bit count and latched ID length for the transaction in flight.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            n_lat   <= 5'd0;
            bit_cnt <= 5'd0;
        end else if (start) begin
            n_lat   <= N_BITS_TRIGGER_ID;
            bit_cnt <= 5'd0;
        end else if (sample) begin
            bit_cnt <= bit_cnt + 5'd1;
        end
    end

    // ID shift register, sampled on the last cycle of each low phase.
    always_ff @(posedge SYS_CLK) begin
        if (start)       shreg          <= '0;
        else if (sample) shreg[bit_cnt] <= trg_s;
    end

    // Registered handshake and strobe outputs.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            TLU_BUSY        <= 1'b0;
            TLU_CLOCK       <= 1'b0;
            TRIG_VALID      <= 1'b0;
            ID_ERROR        <= 1'b0;
            TIME_OUT        <= 1'b0;
            TLU_RESET_PULSE <= 1'b0;
            TRIG_ID         <= '0;
            TRIG_CNT        <= 16'd0;
        end else begin
            TLU_BUSY        <= (state != IDLE);
            TLU_CLOCK       <= (state == CLK_HI);
            TRIG_VALID      <= (state == DONE);
            ID_ERROR        <= (state == DONE) && have_prev && (n_lat != 5'd0) &&
                               (rx_id != expect_id);
            TIME_OUT        <= tmo_fire;
            TLU_RESET_PULSE <= rst_rise;
            if (state == DONE) TRIG_ID  <= rx_id;
            if (TRIG_VALID)    TRIG_CNT <= TRIG_CNT + 16'd1;
        end
    end

    // ID continuity history; a TLU reset forgets the previous ID.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            have_prev <= 1'b0;
            expect_id <= '0;
        end else begin
            if ((state == DONE) && (n_lat != 5'd0))
                expect_id <= (rx_id + 31'd1) & id_mask(n_lat);
            if (rst_rise)
                have_prev <= 1'b0;
            else if ((state == DONE) && (n_lat != 5'd0))
                have_prev <= 1'b1;
        end
    end

`ifdef TLU_DUT_RX_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_cap;

    // Free-running timestamp counter.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) ts_cnt <= 32'd0;
        else         ts_cnt <= ts_cnt + 32'd1;
    end

    // Capture at transaction start, publish together with TRIG_VALID.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            ts_cap         <= 32'd0;
            TRIG_TIMESTAMP <= 32'd0;
        end else begin
            if (start)         ts_cap         <= ts_cnt;
            if (state == DONE) TRIG_TIMESTAMP <= ts_cap;
        end
    end
`endif

endmodule

// File: tb/tb_tlu_dut_rx.sv
// Directed bench for tlu_dut_rx: a master model drives the trigger line and
// returns IDs LSB first on each TLU_CLOCK rising edge.
module tb_tlu_dut_rx;

    localparam int H = 4;

    logic        SYS_CLK = 1'b0;
    logic        SYS_RST;
    logic        ENABLE;
    logic [4:0]  N_BITS_TRIGGER_ID;
    logic [15:0] CONF_TIME_OUT;
    logic        DUT_HOLD;
    logic        TLU_TRIGGER;
    logic        TLU_RESET;
    logic        TLU_BUSY;
    logic        TLU_CLOCK;
    logic        TRIG_VALID;
    logic [30:0] TRIG_ID;
    logic        ID_ERROR;
    logic        TIME_OUT;
    logic        TLU_RESET_PULSE;
    logic [15:0] TRIG_CNT;

    int n_chk = 0;
    int n_err = 0;

    int cyc = 0, rises = 0, shape_bad = 0, hi_run = 0, lo_run = 0;
    int valid_cnt = 0, id_err_cnt = 0, to_cnt = 0, rst_pulse_cnt = 0;
    int busy_rise_cyc = 0, to_cyc = 0;
    logic [30:0] last_id = '0;
    bit clk_prev = 0, busy_prev = 0, lo_active = 0;

    tlu_dut_rx #(.CLK_HALF_PERIOD(H)) dut (
        .SYS_CLK           (SYS_CLK),
        .SYS_RST           (SYS_RST),
        .ENABLE            (ENABLE),
        .N_BITS_TRIGGER_ID (N_BITS_TRIGGER_ID),
        .CONF_TIME_OUT     (CONF_TIME_OUT),
        .DUT_HOLD          (DUT_HOLD),
        .TLU_TRIGGER       (TLU_TRIGGER),
        .TLU_RESET         (TLU_RESET),
        .TLU_BUSY          (TLU_BUSY),
        .TLU_CLOCK         (TLU_CLOCK),
        .TRIG_VALID        (TRIG_VALID),
        .TRIG_ID           (TRIG_ID),
        .ID_ERROR          (ID_ERROR),
        .TIME_OUT          (TIME_OUT),
        .TLU_RESET_PULSE   (TLU_RESET_PULSE),
        .TRIG_CNT          (TRIG_CNT)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    // Output monitor on the inactive edge.
    always @(negedge SYS_CLK) begin
        cyc++;
        if (TLU_CLOCK === 1'b1) begin
            if (!clk_prev) begin
                rises++;
                if (lo_active && lo_run != H) shape_bad++;
            end
            hi_run = clk_prev ? hi_run + 1 : 1;
        end else begin
            if (clk_prev) begin
                if (hi_run != H) shape_bad++;
                lo_active = 1;
                lo_run = 1;
            end else begin
                lo_run++;
            end
        end
        if (TLU_BUSY !== 1'b1) lo_active = 0;
        clk_prev = (TLU_CLOCK === 1'b1);
        if (TLU_BUSY === 1'b1 && !busy_prev) busy_rise_cyc = cyc;
        busy_prev = (TLU_BUSY === 1'b1);
        if (TRIG_VALID === 1'b1) begin
            valid_cnt++;
            last_id = TRIG_ID;
        end
        if (ID_ERROR === 1'b1) id_err_cnt++;
        if (TIME_OUT === 1'b1) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if (TLU_RESET_PULSE === 1'b1) rst_pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge SYS_CLK);
            #1;
        end
    endtask

    // Master side of one transaction: trigger pulse, then one ID bit per clock.
    task automatic run_trig(input logic [30:0] id, input int nbits, input int pulse,
                            input bit wait_idle);
        int  r0;
        int  v0;
        bit  ok;
        v0 = valid_cnt;
        N_BITS_TRIGGER_ID = 5'(nbits);
        TLU_TRIGGER = 1'b1;
        tick(pulse);
        TLU_TRIGGER = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            r0 = rises;
            ok = 0;
            for (int t = 0; t < 200 && !ok; t++) begin
                tick(1);
                if (rises != r0) ok = 1;
            end
            if (!ok) begin
                check("clk_rise_wait", 32'(ok), 1);
                return;
            end
            TLU_TRIGGER = id[k];
        end
        ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            tick(1);
            if (valid_cnt != v0) ok = 1;
        end
        TLU_TRIGGER = 1'b0;
        if (!ok) check("valid_wait", 32'(ok), 1);
        if (wait_idle) begin
            ok = 0;
            for (int t = 0; t < 100 && !ok; t++) begin
                tick(1);
                if (TLU_BUSY === 1'b0) ok = 1;
            end
            if (!ok) check("idle_wait", 32'(ok), 1);
        end
    endtask

    task automatic pulse_tlu_reset();
        TLU_RESET = 1'b1;
        tick(3);
        TLU_RESET = 1'b0;
        tick(4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        int  v0, r0, e0, t0, b0, c0, p0, low_seen;
        bit  ok;

        SYS_RST = 1'b1;
        ENABLE = 1'b0;
        N_BITS_TRIGGER_ID = 5'd0;
        CONF_TIME_OUT = 16'd0;
        DUT_HOLD = 1'b0;
        TLU_TRIGGER = 1'b0;
        TLU_RESET = 1'b0;
        tick(3);
        check("rst_busy", 32'(TLU_BUSY), 0);
        check("rst_clock", 32'(TLU_CLOCK), 0);
        check("rst_valid", 32'(TRIG_VALID), 0);
        check("rst_id", 32'(TRIG_ID), 0);
        check("rst_cnt", 32'(TRIG_CNT), 0);
        check("rst_flags", {29'd0, ID_ERROR, TIME_OUT, TLU_RESET_PULSE}, 0);
        SYS_RST = 1'b0;
        ENABLE = 1'b1;
        tick(3);

        // Trigger edges are ignored while disabled.
        ENABLE = 1'b0;
        TLU_TRIGGER = 1'b1;
        tick(10);
        check("dis_busy", 32'(TLU_BUSY), 0);
        TLU_TRIGGER = 1'b0;
        tick(5);
        ENABLE = 1'b1;

        // Handshake only, 20-cycle trigger pulse.
        v0 = valid_cnt; r0 = rises; e0 = id_err_cnt;
        N_BITS_TRIGGER_ID = 5'd0;
        TLU_TRIGGER = 1'b1;
        tick(3);
        check("hs_busy_early", 32'(TLU_BUSY), 0);
        tick(1);
        check("hs_busy_n3", 32'(TLU_BUSY), 1);
        tick(16);
        TLU_TRIGGER = 1'b0;
        ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            tick(1);
            if (TLU_BUSY === 1'b0) ok = 1;
        end
        check("hs_idle", 32'(ok), 1);
        check("hs_valids", 32'(valid_cnt - v0), 1);
        check("hs_id", 32'(last_id), 0);
        check("hs_cnt", 32'(TRIG_CNT), 1);
        check("hs_no_clock", 32'(rises - r0), 0);
        check("hs_no_err", 32'(id_err_cnt - e0), 0);

        // 15-bit readout of 0x1234.
        r0 = rises; b0 = shape_bad;
        run_trig(31'h1234, 15, 5, 1);
        check("rd_id", 32'(last_id), 32'h1234);
        check("rd_pulses", 32'(rises - r0), 15);
        check("rd_shape", 32'(shape_bad - b0), 0);
        check("rd_cnt", 32'(TRIG_CNT), 2);

        // ID continuity: 5, 6, 8 after a TLU reset.
        p0 = rst_pulse_cnt;
        pulse_tlu_reset();
        check("tlu_rst_pulse", 32'(rst_pulse_cnt - p0), 1);
        e0 = id_err_cnt;
        run_trig(31'd5, 8, 5, 1);
        check("seq5_err", 32'(id_err_cnt - e0), 0);
        run_trig(31'd6, 8, 5, 1);
        check("seq6_err", 32'(id_err_cnt - e0), 0);
        run_trig(31'd8, 8, 5, 1);
        check("seq8_err", 32'(id_err_cnt - e0), 1);
        check("seq8_id", 32'(last_id), 8);
        pulse_tlu_reset();
        e0 = id_err_cnt;
        run_trig(31'hFF, 8, 5, 1);
        run_trig(31'h00, 8, 5, 1);
        check("wrap_err", 32'(id_err_cnt - e0), 0);
        check("wrap_id", 32'(last_id), 0);
        check("seq_cnt", 32'(TRIG_CNT), 7);

        // Timeout with the trigger line stuck high.
        CONF_TIME_OUT = 16'd100;
        N_BITS_TRIGGER_ID = 5'd8;
        v0 = valid_cnt; t0 = to_cnt; c0 = 32'(TRIG_CNT);
        TLU_TRIGGER = 1'b1;
        ok = 0;
        for (int t = 0; t < 300 && !ok; t++) begin
            tick(1);
            if (to_cnt != t0) ok = 1;
        end
        check("to_seen", 32'(ok), 1);
        check("to_latency", 32'(to_cyc - busy_rise_cyc), 99);
        tick(20);
        check("to_busy_held", 32'(TLU_BUSY), 1);
        check("to_width", 32'(to_cnt - t0), 1);
        TLU_TRIGGER = 1'b0;
        tick(10);
        check("to_busy_drop", 32'(TLU_BUSY), 0);
        check("to_no_valid", 32'(valid_cnt - v0), 0);
        check("to_cnt_same", 32'(TRIG_CNT), 32'(c0));
        CONF_TIME_OUT = 16'd0;

        // DUT_HOLD keeps BUSY up; a trigger during HOLD is dropped.
        DUT_HOLD = 1'b1;
        e0 = id_err_cnt;
        run_trig(31'd1, 8, 5, 0);
        low_seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (TLU_BUSY !== 1'b1) low_seen++;
            if (i == 20) TLU_TRIGGER = 1'b1;
            if (i == 25) TLU_TRIGGER = 1'b0;
        end
        check("hold_busy", 32'(low_seen), 0);
        check("hold_no_err", 32'(id_err_cnt - e0), 0);
        v0 = valid_cnt;
        DUT_HOLD = 1'b0;
        tick(10);
        check("hold_release", 32'(TLU_BUSY), 0);
        tick(20);
        check("hold_edge_ignored", 32'(TLU_BUSY), 0);
        check("hold_no_valid", 32'(valid_cnt - v0), 0);
        check("hold_cnt", 32'(TRIG_CNT), 8);

        // SYS_RST during the low phase of bit 3.
        N_BITS_TRIGGER_ID = 5'd8;
        TLU_TRIGGER = 1'b1;
        tick(5);
        TLU_TRIGGER = 1'b0;
        ok = 1;
        for (int k = 0; k < 4 && ok; k++) begin
            r0 = rises;
            ok = 0;
            for (int t = 0; t < 200 && !ok; t++) begin
                tick(1);
                if (rises != r0) ok = 1;
            end
            TLU_TRIGGER = k[0] ? 1'b0 : 1'b1;
        end
        check("sr_bits_seen", 32'(ok), 1);
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            tick(1);
            if (TLU_CLOCK === 1'b0) ok = 1;
        end
        check("sr_low_phase", 32'(ok), 1);
        tick(2);
        SYS_RST = 1'b1;
        TLU_TRIGGER = 1'b0;
        tick(1);
        check("sr_busy", 32'(TLU_BUSY), 0);
        check("sr_clock", 32'(TLU_CLOCK), 0);
        check("sr_id", 32'(TRIG_ID), 0);
        check("sr_cnt", 32'(TRIG_CNT), 0);
        check("sr_flags", {29'd0, TRIG_VALID, ID_ERROR, TIME_OUT}, 0);
        SYS_RST = 1'b0;
        tick(3);
        e0 = id_err_cnt;
        run_trig(31'h3C, 8, 5, 1);
        check("sr_after_id", 32'(last_id), 32'h3C);
        check("sr_after_cnt", 32'(TRIG_CNT), 1);
        check("sr_after_err", 32'(id_err_cnt - e0), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
